// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among
// NUM_REQ writeback requesters, with collision reporting and grant counters.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      CLK,
  input  logic                      Reset_n,
  input  logic                      Enable,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  input  logic [NUM_REQ*ADDR_W-1:0] Req_Addr,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Req_Ready,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         RegWriteData,
  output logic [1:0]                Grant_Id,
  output logic                      Conflict,
  output logic [NUM_REQ*CNT_W-1:0]  Grant_Count
);

  logic [1:0]        r_ptr;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_grant_id;
  logic              r_conflict;
  logic [CNT_W-1:0]  r_cnt [NUM_REQ];

  logic               w_found;
  logic [1:0]         w_win;
  logic [1:0]         w_next_ptr;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_conflict;

  // Round-robin search: first valid requester at or after r_ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (Enable && Reset_n && !w_found && Req_Valid[i] &&
            (((int'(r_ptr) + k) % NUM_REQ) == i)) begin
          w_found = 1'b1;
          w_win   = 2'(i);
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  // One-hot ready toward the winner, next pointer past the winner.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_found && (w_win == 2'(i));
    end
    if (w_win == 2'(NUM_REQ - 1)) begin
      w_next_ptr = 2'd0;
    end else begin
      w_next_ptr = w_win + 2'd1;
    end
  end

  // Any two valid requests aimed at the same register, independent of Enable.
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        w_conflict = w_conflict | (Req_Valid[i] & Req_Valid[j] &
                     (Req_Addr[i*ADDR_W +: ADDR_W] == Req_Addr[j*ADDR_W +: ADDR_W]));
      end
    end
  end

  // Output write register, pointer and conflict flop.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr      <= 2'd0;
      r_regwrite <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_grant_id <= 2'd0;
      r_conflict <= 1'b0;
    end else begin
      r_regwrite <= w_found;
      r_conflict <= w_conflict;
      if (w_found) begin
        r_ptr      <= w_next_ptr;
        r_waddr    <= Req_Addr[w_win*ADDR_W +: ADDR_W];
        r_wdata    <= Req_Data[w_win*DATA_W +: DATA_W];
        r_grant_id <= w_win;
      end
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_ready[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign Grant_Count[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign Req_Ready     = w_ready;
  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_waddr;
  assign RegWriteData  = r_wdata;
  assign Grant_Id      = r_grant_id;
  assign Conflict      = r_conflict;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the driver predicts each edge's outcome from a round-robin
// model and queues it; a negedge monitor pops and compares the registered outputs.
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic [2:0]  Req_Valid;
  logic [5:0]  Req_Addr;
  logic [23:0] Req_Data;
  logic [2:0]  Req_Ready;
  logic        RegWrite;
  logic [1:0]  WriteRegister;
  logic [7:0]  RegWriteData;
  logic [1:0]  Grant_Id;
  logic        Conflict;
  logic [23:0] Grant_Count;

  regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(8), .ADDR_W(2), .CNT_W(8)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Enable(Enable),
    .Req_Valid(Req_Valid), .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .RegWriteData(RegWriteData), .Grant_Id(Grant_Id), .Conflict(Conflict),
    .Grant_Count(Grant_Count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    logic [1:0] id;
    logic       cf;
    int         c0, c1, c2;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  // Stimulus variables applied by step()
  logic       tb_en;
  logic [2:0] tb_valid;
  logic [1:0] tb_addr [3];
  logic [7:0] tb_data [3];

  // Reference model state
  int         m_ptr;
  int         m_cnt [3];
  logic [1:0] m_addr;
  logic [7:0] m_data;
  logic [1:0] m_id;
  int         m_win;

  // Bench-side register file fed by the arbiter's write port
  logic [7:0] rf [4];
  always @(posedge CLK) if (RegWrite) rf[WriteRegister] <= RegWriteData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_addr = 2'd0; m_data = 8'd0; m_id = 2'd0; m_win = -1;
  endtask

  // Apply stimulus, check Ready, predict the next edge and queue it.
  task automatic step();
    rec_t r;
    logic [2:0] exp_rdy;
    logic cf;
    @(negedge CLK); #1;
    Enable    = tb_en;
    Req_Valid = tb_valid;
    Req_Addr  = {tb_addr[2], tb_addr[1], tb_addr[0]};
    Req_Data  = {tb_data[2], tb_data[1], tb_data[0]};
    #1;
    m_win = -1;
    if (tb_en) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_ptr + k) % 3;
        if (m_win < 0 && tb_valid[i]) m_win = i;
      end
    end
    exp_rdy = (m_win >= 0) ? (3'b001 << m_win) : 3'b000;
    chk("req_ready", {29'd0, Req_Ready}, {29'd0, exp_rdy});
    cf = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (tb_valid[i] && tb_valid[j] && tb_addr[i] == tb_addr[j]) cf = 1'b1;
    if (m_win >= 0) begin
      m_addr = tb_addr[m_win];
      m_data = tb_data[m_win];
      m_id   = 2'(m_win);
      if (m_cnt[m_win] < 255) m_cnt[m_win]++;
      m_ptr = (m_win + 1) % 3;
    end
    r.rw = (m_win >= 0); r.addr = m_addr; r.data = m_data; r.id = m_id; r.cf = cf;
    r.c0 = m_cnt[0]; r.c1 = m_cnt[1]; r.c2 = m_cnt[2];
    exp_q.push_back(r);
  endtask

  // Idle the inputs and let queued predictions and register writes settle.
  task automatic drain();
    @(negedge CLK); #1;
    tb_valid = 3'b000; Req_Valid = 3'b000;
    @(negedge CLK); #1;
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    Reset_n = 1'b0;
    Req_Valid = 3'b000; tb_valid = 3'b000;
    exp_q.delete();
    model_reset();
    #3;
    @(negedge CLK);
    Reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: one prediction per clock edge, compared on the following negedge.
  always @(negedge CLK) begin
    if (mon_en && exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      chk("regwrite", RegWrite, r.rw);
      chk("write_register", WriteRegister, r.addr);
      chk("regwrite_data", RegWriteData, r.data);
      chk("grant_id", Grant_Id, r.id);
      chk("conflict", Conflict, r.cf);
      chk("grant_count0", Grant_Count[7:0], r.c0);
      chk("grant_count1", Grant_Count[15:8], r.c1);
      chk("grant_count2", Grant_Count[23:16], r.c2);
    end
  end

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; Req_Valid = 3'b000; Req_Addr = 6'd0; Req_Data = 24'd0;
    tb_en = 1'b1; tb_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin tb_addr[i] = 2'd0; tb_data[i] = 8'd0; end
    for (int i = 0; i < 4; i++) rf[i] = 8'd0;
    model_reset();
    #12;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_waddr", WriteRegister, 0);
    chk("rst_wdata", RegWriteData, 0);
    chk("rst_grant_id", Grant_Id, 0);
    chk("rst_conflict", Conflict, 0);
    chk("rst_counts", Grant_Count, 0);
    do_reset();

    // Single request from R1
    tb_en = 1'b1; tb_valid = 3'b010; tb_addr[1] = 2'd2; tb_data[1] = 8'h5A;
    step();
    tb_valid = 3'b000;
    step();
    drain();

    // All three continuously valid from reset
    do_reset();
    tb_valid = 3'b111;
    tb_addr[0] = 2'd0; tb_addr[1] = 2'd1; tb_addr[2] = 2'd2;
    tb_data[0] = 8'hA0; tb_data[1] = 8'hB1; tb_data[2] = 8'hC2;
    for (int n = 0; n < 6; n++) step();
    drain();

    // Collision on register 3: R0 then R2, last writer wins
    do_reset();
    tb_valid = 3'b101;
    tb_addr[0] = 2'd3; tb_data[0] = 8'h11; tb_addr[2] = 2'd3; tb_data[2] = 8'h22;
    step();
    tb_valid = 3'b100;
    step();
    drain();
    chk("rf3_last_writer", rf[3], 8'h22);

    // Enable low holds off R0, then first edge after enable accepts it
    tb_en = 1'b0; tb_valid = 3'b001; tb_addr[0] = 2'd1; tb_data[0] = 8'h3C;
    for (int n = 0; n < 3; n++) step();
    tb_en = 1'b1;
    step();
    tb_valid = 3'b000;
    step();
    drain();

    // Randomized traffic; requesters hold addr/data until accepted
    tb_valid = 3'b000;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!tb_valid[i] && $urandom_range(0, 2) != 0) begin
          tb_valid[i] = 1'b1;
          tb_addr[i] = 2'($urandom_range(0, 3));
          tb_data[i] = 8'($urandom_range(0, 255));
        end
      end
      tb_en = ($urandom_range(0, 7) != 0);
      step();
      if (m_win >= 0) tb_valid[m_win] = 1'b0;
    end
    tb_en = 1'b1;
    drain();

    // Asynchronous reset while a write is being presented
    tb_valid = 3'b001; tb_addr[0] = 2'd2; tb_data[0] = 8'h77;
    step();
    @(posedge CLK); #2;
    chk("pre_reset_regwrite", RegWrite, 1);
    mon_en = 1'b0;
    exp_q.delete();
    Reset_n = 1'b0;
    #1;
    chk("async_rst_regwrite", RegWrite, 0);
    chk("async_rst_counts", Grant_Count, 0);
    chk("async_rst_ready", Req_Ready, 0);
    model_reset();
    Req_Valid = 3'b000; tb_valid = 3'b000;
    @(negedge CLK);
    Reset_n = 1'b1;
    mon_en = 1'b1;
    tb_valid = 3'b011; tb_addr[1] = 2'd1; tb_data[1] = 8'h66;
    step();
    tb_valid = 3'b010;
    step();
    tb_valid = 3'b000;
    drain();

    // Saturation: R0 alone for 300 grants
    do_reset();
    tb_valid = 3'b001; tb_addr[0] = 2'd0;
    for (int n = 0; n < 300; n++) begin
      tb_data[0] = 8'(n);
      step();
    end
    drain();
    chk("saturated_count0", Grant_Count[7:0], 8'd255);
    chk("saturated_count1", Grant_Count[15:8], 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
